// File: rtl/commit_writeback_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : commit_writeback_pkg                                              |
// | Brief  : Shared types for the commit/writeback slice: architectural word,  |
// |          register index, write-queue entry and the stack-pointer index.    |
// | Macros : NUMBER_OF_REGISTERS, DATA_SIZE (defaults supplied when absent)    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef NUMBER_OF_REGISTERS
`define NUMBER_OF_REGISTERS 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package commit_writeback_pkg;

  localparam int REG_IDX_W = $clog2(`NUMBER_OF_REGISTERS);

  typedef logic [`DATA_SIZE-1:0] MemoryWord;
  typedef logic [REG_IDX_W-1:0]  Register;

  // One pending architectural write.
  typedef struct packed {
    Register   rd;
    MemoryWord data;
  } WbEntry;

  // x2 holds the stack pointer and has a non-zero reset value.
  localparam Register SP_REG = Register'(2);

endpackage

`default_nettype wire

// File: rtl/commit_writeback_wb_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : wb_fifo                                                           |
// | Brief  : 2-push / 1-pop circular queue of WbEntry.  Exposes the occupancy  |
// |          and the whole contents re-ordered by age (entries[0] = head =     |
// |          oldest) together with per-slot valid bits.                        |
// | Ports  : clk, reset (async, active-low), push_cnt, push_data[2], pop,      |
// |          count, entries[DEPTH], valid[DEPTH]                               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo
  import commit_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               push_cnt,       // 0, 1 or 2; push_data[0] goes first
  input  WbEntry                   push_data [2],
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output WbEntry                   entries [DEPTH], // age order, [0] is the head
  output logic [DEPTH-1:0]         valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  WbEntry             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   w_tail_p1;

  assign w_tail_p1 = r_tail + 1'b1;

  // Storage needs no reset: slots are only observed through valid bits.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) r_mem[r_tail]    <= push_data[0];
    if (push_cnt == 2'd2) r_mem[w_tail_p1] <= push_data[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(push_cnt);   // wraps modulo DEPTH
      if (pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

  assign count = r_count;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      entries[j] = r_mem[r_head + PTR_W'(j)];
      valid[j]   = (CNT_W'(j) < r_count);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    pop |-> (r_count != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (r_count + CNT_W'(push_cnt) - CNT_W'(pop)) <= CNT_W'(DEPTH));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    r_count <= CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/commit_writeback.sv
// +----------------------------------------------------------------------------+
// | Module : commit_writeback                                                  |
// | Brief  : Architectural register file owner.  Takes up to two in-order     |
// |          commits per cycle into a write queue and drains one write per     |
// |          cycle into the array.                                             |
// | Ports  : clk, reset (async, active-low), commit_valid[2], commit_rd[2],    |
// |          commit_data[2], commit_ready, register_file[NREG], pending_mask   |
// | Macro  : WB_BYPASS_EN - overlay queued writes onto register_file           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module commit_writeback
  import commit_writeback_pkg::*;
#(
  parameter int        WB_DEPTH = 4,
  parameter MemoryWord SP_INIT  = 32'h0001_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      commit_valid,
  input  Register                         commit_rd   [2],
  input  MemoryWord                       commit_data [2],
  output logic                            commit_ready,
  output MemoryWord                       register_file [`NUMBER_OF_REGISTERS],
  output logic [`NUMBER_OF_REGISTERS-1:0] pending_mask
);

  localparam int NREG  = `NUMBER_OF_REGISTERS;
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic [CNT_W-1:0]    w_count;
  WbEntry              w_entries [WB_DEPTH];
  logic [WB_DEPTH-1:0] w_valid;
  logic                w_take0;
  logic                w_take1;
  logic [1:0]          w_push_cnt;
  WbEntry              w_push_data [2];
  MemoryWord           r_regs [NREG];

  // Ready looks only at registered occupancy, so a pair is never split and a
  // same-cycle drain cannot create room combinationally.
  assign commit_ready = (w_count <= CNT_W'(WB_DEPTH - 2));

  // Writes to x0 are dropped before they take a queue slot.
  assign w_take0    = commit_ready && commit_valid[0] && (commit_rd[0] != '0);
  assign w_take1    = commit_ready && commit_valid[1] && (commit_rd[1] != '0);
  assign w_push_cnt = {1'b0, w_take0} + {1'b0, w_take1};

  // Compact the accepted lanes so the older one is always pushed first.
  always_comb begin
    w_push_data[0] = w_take0 ? WbEntry'({commit_rd[0], commit_data[0]})
                             : WbEntry'({commit_rd[1], commit_data[1]});
    w_push_data[1] = WbEntry'({commit_rd[1], commit_data[1]});
  end

  wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_cnt  (w_push_cnt),
    .push_data (w_push_data),
    .pop       (w_valid[0]),
    .count     (w_count),
    .entries   (w_entries),
    .valid     (w_valid)
  );

  // Drain: the head entry (valid[0] <=> count > 0) lands every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= (r == int'(SP_REG)) ? SP_INIT : '0;
      end
    end else if (w_valid[0]) begin
      r_regs[w_entries[0].rd] <= w_entries[0].data;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int j = 0; j < WB_DEPTH; j++) begin
      if (w_valid[j]) pending_mask[w_entries[j].rd] = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Overlay in age order so the youngest queued write to a register wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) register_file[r] = r_regs[r];
    for (int j = 0; j < WB_DEPTH; j++) begin
      if (w_valid[j]) register_file[w_entries[j].rd] = w_entries[j].data;
    end
  end
`else
  always_comb begin
    for (int r = 0; r < NREG; r++) register_file[r] = r_regs[r];
  end
`endif

endmodule

`default_nettype wire
